cluster_tcdm_arb_ctrl: RTL and testbench

- Sequential priority controller for the cluster TCDM heterogeneous interconnect.
- Watches request/grant activity of the two competing branches:
  - the logarithmic branch (cores, DMA, external ports);
  - the HWPE shallow branch.
- Drives the single priority select that decides which branch wins bank conflicts.
- Sits next to the interconnect wrapper in the cluster top and replaces a static arbitration-policy input with a configurable policy: fixed, starvation-aware or time-sliced.

---
 rtl/cluster_arb_package.sv | 30 +++
 rtl/cluster_arb_stall_cnt.sv | 47 ++++
 rtl/cluster_tcdm_arb_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_cluster_tcdm_arb_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cluster_arb_package.sv
`default_nettype none
// ============================================================================
// Module   : cluster_arb_package
// Purpose  : Shared types and defaults for the cluster TCDM priority
//            controller (policy and FSM state encodings, default widths).
// Revision : 1.0 - initial release
// ============================================================================
package cluster_arb_package;

  // Arbitration policy, encoded as the 2-bit policy_i input.
  typedef enum logic [1:0] {
    POL_FIX_LOG  = 2'b00,
    POL_FIX_HWPE = 2'b01,
    POL_STARV    = 2'b10,
    POL_SLICE    = 2'b11
  } arb_policy_e;

  // Controller FSM states.
  typedef enum logic [1:0] {
    ST_DEF_LOG  = 2'b00,
    ST_DEF_HWPE = 2'b01,
    ST_HOLD     = 2'b10,
    ST_SLICE    = 2'b11
  } arb_state_e;

  localparam int CNT_W_DEFAULT  = 8;
  localparam int STAT_W_DEFAULT = 32;

endpackage
`default_nettype wire

// File: rtl/cluster_arb_stall_cnt.sv
`default_nettype none
// ============================================================================
// Module   : cluster_arb_stall_cnt
// Purpose  : Saturating consecutive-stall counter for one interconnect branch.
//            A stall is req && !gnt; any non-stall cycle zeroes the count.
// Ports    : clk_i, rst_i (async, active-high), clr_i (sync clear),
//            req_i, gnt_i          - branch handshake
//            cnt_nxt_o             - count including the current cycle
// Revision : 1.0 - initial release
// ============================================================================
module cluster_arb_stall_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             req_i,
  input  logic             gnt_i,
  output logic [CNT_W-1:0] cnt_nxt_o
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_stall;

  assign w_stall = req_i & ~gnt_i;

  // Exporting the next value lets the threshold compare see the stall of the
  // current cycle, so a swap can land on the edge that ends that cycle.
  always_comb begin
    cnt_nxt_o = '0;
    if (w_stall) begin
      cnt_nxt_o = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= cnt_nxt_o;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cluster_tcdm_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cluster_tcdm_arb_ctrl
// Purpose  : Sequential priority controller selecting whether the LOG branch
//            or the HWPE branch wins TCDM bank conflicts. Policies: fixed LOG,
//            fixed HWPE, starvation-aware swap with hold, time-sliced.
// Ports    : clk_i, rst_i (async, active-high), clear_i (sync clear)
//            policy_i, stall_thr_i, hold_len_i, slice_len_i - configuration
//            log_req_i/log_gnt_i, hwpe_req_i/hwpe_gnt_i     - branch activity
//            hwpe_prio_o   - 1 = HWPE wins conflicts (flop output)
//            swap_active_o - high while the swapped priority is held
//            stat_log_stall_o/stat_hwpe_stall_o - stall statistics
// Config   : CLUSTER_TCDM_ARB_CTRL_STATS_EN enables the statistics counters;
//            otherwise the statistics outputs are constant 0.
// Revision : 1.0 - initial release
// ============================================================================
module cluster_tcdm_arb_ctrl
  import cluster_arb_package::*;
#(
  parameter int CNT_W  = CNT_W_DEFAULT,
  parameter int STAT_W = STAT_W_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic [1:0]        policy_i,
  input  logic [CNT_W-1:0]  stall_thr_i,
  input  logic [CNT_W-1:0]  hold_len_i,
  input  logic [CNT_W-1:0]  slice_len_i,
  input  logic              log_req_i,
  input  logic              log_gnt_i,
  input  logic              hwpe_req_i,
  input  logic              hwpe_gnt_i,
  output logic              hwpe_prio_o,
  output logic              swap_active_o,
  output logic [STAT_W-1:0] stat_log_stall_o,
  output logic [STAT_W-1:0] stat_hwpe_stall_o
);

  localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

  arb_state_e       r_state, w_state_nxt;
  arb_policy_e      r_policy;
  arb_policy_e      w_pol;
  logic             r_prio, w_prio_nxt;
  logic [CNT_W-1:0] r_hold, w_hold_nxt;
  logic [CNT_W-1:0] r_slice, w_slice_nxt;
  logic             w_pol_chg;
  logic             w_clr_log, w_clr_hwpe;
  logic [CNT_W-1:0] w_log_cnt_nxt, w_hwpe_cnt_nxt;
  logic [CNT_W-1:0] w_low_cnt;
  logic             w_thr_hit;
  logic [CNT_W-1:0] w_hold_len, w_slice_len, w_slice_rem;

  assign w_pol     = arb_policy_e'(policy_i);
  assign w_pol_chg = (w_pol != r_policy);

  assign w_hold_len  = (hold_len_i  == '0) ? c_one : hold_len_i;
  assign w_slice_len = (slice_len_i == '0) ? c_one : slice_len_i;

  // A zero slice counter means "phase not started": the length is sampled on
  // the first cycle of every phase, so each phase lasts exactly the length.
  assign w_slice_rem = (r_slice == '0) ? w_slice_len : r_slice;

  cluster_arb_stall_cnt #(.CNT_W(CNT_W)) u_log_stall (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (clear_i | w_clr_log),
    .req_i     (log_req_i),
    .gnt_i     (log_gnt_i),
    .cnt_nxt_o (w_log_cnt_nxt)
  );

  cluster_arb_stall_cnt #(.CNT_W(CNT_W)) u_hwpe_stall (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (clear_i | w_clr_hwpe),
    .req_i     (hwpe_req_i),
    .gnt_i     (hwpe_gnt_i),
    .cnt_nxt_o (w_hwpe_cnt_nxt)
  );

  // Only the branch that currently loses conflicts is evaluated.
  assign w_low_cnt = r_prio ? w_log_cnt_nxt : w_hwpe_cnt_nxt;
  assign w_thr_hit = (stall_thr_i != '0) && (w_low_cnt >= stall_thr_i);

  always_comb begin
    w_state_nxt = r_state;
    w_prio_nxt  = r_prio;
    w_hold_nxt  = r_hold;
    w_slice_nxt = r_slice;
    w_clr_log   = 1'b0;
    w_clr_hwpe  = 1'b0;

    if (w_pol_chg) begin
      // Restart cleanly in the default state of the new policy.
      w_clr_log   = 1'b1;
      w_clr_hwpe  = 1'b1;
      w_hold_nxt  = '0;
      w_slice_nxt = '0;
      case (w_pol)
        POL_FIX_HWPE: begin
          w_state_nxt = ST_DEF_HWPE;
          w_prio_nxt  = 1'b1;
        end
        POL_SLICE: begin
          w_state_nxt = ST_SLICE;
          w_prio_nxt  = 1'b0;
        end
        default: begin
          w_state_nxt = ST_DEF_LOG;
          w_prio_nxt  = 1'b0;
        end
      endcase
    end else begin
      case (r_state)
        ST_DEF_LOG: begin
          w_prio_nxt = 1'b0;
          if ((r_policy == POL_STARV) && w_thr_hit) begin
            w_state_nxt = ST_HOLD;
            w_prio_nxt  = 1'b1;
            w_hold_nxt  = w_hold_len;
            w_clr_log   = 1'b1;
            w_clr_hwpe  = 1'b1;
          end
        end
        ST_DEF_HWPE: begin
          w_prio_nxt = 1'b1;
        end
        ST_HOLD: begin
          w_prio_nxt = 1'b1;
          if (r_hold <= c_one) begin
            w_state_nxt = ST_DEF_LOG;
            w_prio_nxt  = 1'b0;
            w_hold_nxt  = '0;
            w_clr_log   = 1'b1;
          end else begin
            w_hold_nxt = r_hold - c_one;
          end
        end
        ST_SLICE: begin
          if (w_slice_rem == c_one) begin
            w_prio_nxt  = ~r_prio;
            w_slice_nxt = '0;
          end else begin
            w_slice_nxt = w_slice_rem - c_one;
          end
        end
        default: begin
          w_state_nxt = ST_DEF_LOG;
          w_prio_nxt  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ST_DEF_LOG;
      r_policy <= POL_FIX_LOG;
      r_prio   <= 1'b0;
      r_hold   <= '0;
      r_slice  <= '0;
    end else if (clear_i) begin
      r_state  <= ST_DEF_LOG;
      r_policy <= POL_FIX_LOG;
      r_prio   <= 1'b0;
      r_hold   <= '0;
      r_slice  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_policy <= w_pol;
      r_prio   <= w_prio_nxt;
      r_hold   <= w_hold_nxt;
      r_slice  <= w_slice_nxt;
    end
  end

  assign hwpe_prio_o   = r_prio;
  assign swap_active_o = (r_state == ST_HOLD);

`ifdef CLUSTER_TCDM_ARB_CTRL_STATS_EN
  logic [STAT_W-1:0] r_stat_log, r_stat_hwpe;
  logic              w_log_stall, w_hwpe_stall;

  assign w_log_stall  = log_req_i  & ~log_gnt_i;
  assign w_hwpe_stall = hwpe_req_i & ~hwpe_gnt_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stat_log  <= '0;
      r_stat_hwpe <= '0;
    end else if (clear_i) begin
      r_stat_log  <= '0;
      r_stat_hwpe <= '0;
    end else begin
      if (w_log_stall && !(&r_stat_log)) begin
        r_stat_log <= r_stat_log + STAT_W'(1);
      end
      if (w_hwpe_stall && !(&r_stat_hwpe)) begin
        r_stat_hwpe <= r_stat_hwpe + STAT_W'(1);
      end
    end
  end

  assign stat_log_stall_o  = r_stat_log;
  assign stat_hwpe_stall_o = r_stat_hwpe;
`else
  assign stat_log_stall_o  = '0;
  assign stat_hwpe_stall_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cluster_tcdm_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cluster_tcdm_arb_ctrl
// Purpose  : Self-checking bench for cluster_tcdm_arb_ctrl. Per-cycle vectors
//            carry inputs plus the outputs expected in that cycle; expected
//            values are queued when a vector is driven and compared when the
//            outputs are sampled on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cluster_tcdm_arb_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        clear_i;
  logic [1:0]  policy_i;
  logic [7:0]  stall_thr_i, hold_len_i, slice_len_i;
  logic        log_req_i, log_gnt_i, hwpe_req_i, hwpe_gnt_i;
  logic        hwpe_prio_o, swap_active_o;
  logic [31:0] stat_log_stall_o, stat_hwpe_stall_o;

  always #5 clk_i = ~clk_i;

  cluster_tcdm_arb_ctrl #(.CNT_W(8), .STAT_W(32)) u_dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .clear_i           (clear_i),
    .policy_i          (policy_i),
    .stall_thr_i       (stall_thr_i),
    .hold_len_i        (hold_len_i),
    .slice_len_i       (slice_len_i),
    .log_req_i         (log_req_i),
    .log_gnt_i         (log_gnt_i),
    .hwpe_req_i        (hwpe_req_i),
    .hwpe_gnt_i        (hwpe_gnt_i),
    .hwpe_prio_o       (hwpe_prio_o),
    .swap_active_o     (swap_active_o),
    .stat_log_stall_o  (stat_log_stall_o),
    .stat_hwpe_stall_o (stat_hwpe_stall_o)
  );

  typedef struct {
    logic       clr;
    logic [1:0] pol;
    logic [7:0] thr;
    logic [7:0] hold;
    logic [7:0] slice;
    logic       lr, lg, hr, hg;
    logic       eprio;
    logic       eswap;
  } vec_t;

  typedef struct {
    logic prio;
    logic swap;
    int   idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc_idx = 0;

  task automatic add(input logic clr, input logic [1:0] pol, input logic [7:0] thr,
                     input logic [7:0] hold, input logic [7:0] slice,
                     input logic lr, input logic lg, input logic hr, input logic hg,
                     input logic ep, input logic es);
    vec_t v;
    v.clr = clr; v.pol = pol; v.thr = thr; v.hold = hold; v.slice = slice;
    v.lr = lr; v.lg = lg; v.hr = hr; v.hg = hg; v.eprio = ep; v.eswap = es;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one vector just after the rising edge, queue its expectation, then
  // compare the outputs on the falling edge of the same cycle.
  task automatic do_cycle(input vec_t v);
    exp_t e;
    exp_t got;
    clear_i     = v.clr;
    policy_i    = v.pol;
    stall_thr_i = v.thr;
    hold_len_i  = v.hold;
    slice_len_i = v.slice;
    log_req_i   = v.lr;
    log_gnt_i   = v.lg;
    hwpe_req_i  = v.hr;
    hwpe_gnt_i  = v.hg;
    e.prio = v.eprio;
    e.swap = v.eswap;
    e.idx  = cyc_idx;
    sb.push_back(e);
    @(negedge clk_i);
    got = sb.pop_front();
    check($sformatf("prio[%0d]", got.idx), {31'd0, hwpe_prio_o}, {31'd0, got.prio});
    check($sformatf("swap[%0d]", got.idx), {31'd0, swap_active_o}, {31'd0, got.swap});
    cyc_idx++;
    @(posedge clk_i);
    #1;
  endtask

  task automatic cyc(input logic clr, input logic [1:0] pol, input logic [7:0] thr,
                     input logic [7:0] hold, input logic [7:0] slice,
                     input logic lr, input logic lg, input logic hr, input logic hg,
                     input logic ep, input logic es);
    vec_t v;
    v.clr = clr; v.pol = pol; v.thr = thr; v.hold = hold; v.slice = slice;
    v.lr = lr; v.lg = lg; v.hr = hr; v.hg = hg; v.eprio = ep; v.eswap = es;
    do_cycle(v);
  endtask

  logic [31:0] exp_hwpe_stat, exp_log_stat;

  initial begin
    // ---------------- vector table ----------------
    //  clr pol   thr  hold slice  lr lg hr hg  prio swap
    // Starvation swap: thr=4, hold=3, both branches stalled from cycle 0.
    add(1, 2'b10, 4, 3, 0,  0, 0, 0, 0,  0, 0);
    add(0, 2'b10, 4, 3, 0,  0, 0, 0, 0,  0, 0);
    add(0, 2'b10, 4, 3, 0,  0, 0, 0, 0,  0, 0);
    for (int i = 0; i < 4; i++) add(0, 2'b10, 4, 3, 0, 1, 0, 1, 0, 0, 0); // cycles 0-3
    for (int i = 0; i < 3; i++) add(0, 2'b10, 4, 3, 0, 1, 0, 1, 0, 1, 1); // cycles 4-6
    add(0, 2'b10, 4, 3, 0,  1, 1, 0, 0,  0, 0);                           // cycle 7
    // Slicing with slice=2, request activity varies and must not matter.
    add(1, 2'b11, 0, 0, 2,  1, 0, 1, 0,  0, 0);
    add(0, 2'b11, 0, 0, 2,  1, 0, 1, 0,  0, 0);
    add(0, 2'b11, 0, 0, 2,  0, 0, 1, 0,  0, 0);
    add(0, 2'b11, 0, 0, 2,  1, 1, 0, 0,  0, 0);
    add(0, 2'b11, 0, 0, 2,  1, 0, 1, 0,  1, 0);
    add(0, 2'b11, 0, 0, 2,  0, 0, 1, 1,  1, 0);
    add(0, 2'b11, 0, 0, 2,  1, 0, 1, 0,  0, 0);
    add(0, 2'b11, 0, 0, 2,  1, 0, 0, 0,  0, 0);
    add(0, 2'b11, 0, 0, 2,  0, 0, 1, 0,  1, 0);
    // Policy change 10 -> 01 in the middle of HOLD (thr=2, hold=5).
    add(1, 2'b10, 2, 5, 0,  0, 0, 0, 0,  1, 0);
    add(0, 2'b10, 2, 5, 0,  0, 0, 0, 0,  0, 0);
    add(0, 2'b10, 2, 5, 0,  0, 0, 0, 0,  0, 0);
    add(0, 2'b10, 2, 5, 0,  0, 0, 1, 0,  0, 0);
    add(0, 2'b10, 2, 5, 0,  0, 0, 1, 0,  0, 0);
    add(0, 2'b10, 2, 5, 0,  0, 0, 1, 0,  1, 1);
    add(0, 2'b01, 2, 5, 0,  0, 0, 1, 0,  1, 1);
    add(0, 2'b01, 2, 5, 0,  0, 0, 1, 0,  1, 0);
    add(0, 2'b01, 2, 5, 0,  1, 0, 0, 0,  1, 0);
    add(0, 2'b01, 2, 5, 0,  1, 0, 0, 0,  1, 0);
    // hold_len=0 behaves as 1, thr=1 swaps on the first stall.
    add(1, 2'b10, 1, 0, 0,  0, 0, 0, 0,  1, 0);
    add(0, 2'b10, 1, 0, 0,  0, 0, 0, 0,  0, 0);
    add(0, 2'b10, 1, 0, 0,  0, 0, 0, 0,  0, 0);
    add(0, 2'b10, 1, 0, 0,  0, 0, 1, 0,  0, 0);
    add(0, 2'b10, 1, 0, 0,  0, 0, 0, 0,  1, 1);
    add(0, 2'b10, 1, 0, 0,  0, 0, 0, 0,  0, 0);
    add(0, 2'b10, 1, 0, 0,  0, 0, 0, 0,  0, 0);
    // slice_len=0 behaves as 1: priority toggles every cycle.
    add(1, 2'b11, 0, 0, 0,  0, 0, 0, 0,  0, 0);
    add(0, 2'b11, 0, 0, 0,  0, 0, 0, 0,  0, 0);
    add(0, 2'b11, 0, 0, 0,  0, 0, 0, 0,  0, 0);
    add(0, 2'b11, 0, 0, 0,  1, 0, 1, 0,  1, 0);
    add(0, 2'b11, 0, 0, 0,  0, 0, 0, 0,  0, 0);
    add(0, 2'b11, 0, 0, 0,  0, 0, 0, 0,  1, 0);

    // ---------------- reset ----------------
    rst_i = 1'b1;
    clear_i = 1'b0; policy_i = 2'b00; stall_thr_i = 8'd0; hold_len_i = 8'd0;
    slice_len_i = 8'd0; log_req_i = 1'b0; log_gnt_i = 1'b0;
    hwpe_req_i = 1'b0; hwpe_gnt_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_prio", {31'd0, hwpe_prio_o}, 32'd0);
    check("reset_swap", {31'd0, swap_active_o}, 32'd0);
    rst_i = 1'b0;

    foreach (vecs[i]) do_cycle(vecs[i]);

    // ---------------- asynchronous reset in the middle of HOLD ----------------
    cyc(1, 2'b10, 1, 5, 0,  0, 0, 0, 0,  0, 0);
    cyc(0, 2'b10, 1, 5, 0,  0, 0, 0, 0,  0, 0);
    cyc(0, 2'b10, 1, 5, 0,  1, 0, 1, 0,  0, 0);
    cyc(0, 2'b10, 1, 5, 0,  1, 0, 1, 0,  1, 1);
    cyc(0, 2'b10, 1, 5, 0,  1, 0, 1, 0,  1, 1);
    #2;
    rst_i = 1'b1;
    #1;
    check("async_rst_prio", {31'd0, hwpe_prio_o}, 32'd0);
    check("async_rst_swap", {31'd0, swap_active_o}, 32'd0);
    check("async_rst_stat_log", stat_log_stall_o, 32'd0);
    check("async_rst_stat_hwpe", stat_hwpe_stall_o, 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    cyc(0, 2'b10, 1, 5, 0,  0, 0, 0, 0,  0, 0);
    cyc(0, 2'b10, 1, 5, 0,  0, 0, 0, 0,  0, 0);

    // ---------------- threshold 0: no swap, counter saturates ----------------
    cyc(1, 2'b10, 0, 3, 0,  0, 0, 0, 0,  0, 0);
    for (int i = 0; i < 300; i++) cyc(0, 2'b10, 0, 3, 0, 1, 0, 1, 0, 0, 0);
    check("hwpe_stall_sat", {24'd0, u_dut.u_hwpe_stall.r_cnt}, 32'd255);

    // ---------------- statistics ----------------
    cyc(1, 2'b00, 0, 0, 0,  0, 0, 0, 0,  0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++)  cyc(0, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 2'b00, 0, 0, 0,  1, 1, 1, 1,  0, 0);
`ifdef CLUSTER_TCDM_ARB_CTRL_STATS_EN
    exp_hwpe_stat = 32'd10;
    exp_log_stat  = 32'd3;
`else
    exp_hwpe_stat = 32'd0;
    exp_log_stat  = 32'd0;
`endif
    check("stat_hwpe", stat_hwpe_stall_o, exp_hwpe_stat);
    check("stat_log", stat_log_stall_o, exp_log_stat);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
